if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL provide port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL provide port reset, input, 1, asynchronous active-low reset (asserted when 0).
REQ-004 The block SHALL provide port stall_i, input, 1, the ID-stage hold request; IF/ID outputs must not change while it is 1.
REQ-005 The block SHALL provide port redirect_i, input, 1, a branch/jump taken in EX.
REQ-006 The block SHALL provide port redirect_pc_i, input, 32, the redirect target address.
REQ-007 The block SHALL provide port imem_req_o, output, 1, the instruction memory request.
REQ-008 The block SHALL provide port imem_addr_o, output, 32, the fetch address.
REQ-009 The block SHALL provide port imem_ack_i, input, 1, the memory data-valid strobe, one cycle per request.
REQ-010 The block SHALL provide port imem_rdata_i, input, 32, the instruction word, valid when imem_ack_i=1.
REQ-011 The block SHALL provide outputs ifid_valid_o (1), ifid_pc_o (32), ifid_pc4_o (32) and ifid_instr_o (32), which together form the IF/ID pipeline register.

Function
REQ-012 The FSM SHALL have four states:
- START: no request; SHALL go to FETCH on the first edge after reset release.
- FETCH: request outstanding.
- BUFFERED: a word is held while ID is stalled.
- DROP: an outstanding request is being discarded after a redirect.
REQ-013 imem_req_o SHALL be 1 only in FETCH and DROP. imem_addr_o SHALL equal the PC register and SHALL stay stable from request until ack.
REQ-014 FETCH with ack=1 and stall_i=0 SHALL load IF/ID with {valid=1, pc, pc+4, rdata}, set pc<=pc+4 and remain in FETCH.
REQ-015 FETCH with ack=1 and stall_i=1 SHALL capture rdata into a one-entry skid buffer, hold IF/ID and enter BUFFERED.
REQ-016 FETCH with ack=0 and stall_i=0 SHALL clear ifid_valid_o (bubble) and hold the PC. FETCH with ack=0 and stall_i=1 SHALL hold IF/ID.
REQ-017 BUFFERED with stall_i=0 SHALL move the buffer into IF/ID with valid=1, set pc<=pc+4 and return to FETCH. BUFFERED with stall_i=1 SHALL hold all state.
REQ-018 redirect_i=1 SHALL take priority over stall_i and SHALL clear ifid_valid_o on the same edge.
REQ-019 redirect_i=1 in FETCH with ack=1 SHALL discard rdata, set pc<=redirect_pc_i and stay in FETCH.
REQ-020 redirect_i=1 in FETCH with ack=0 SHALL latch the target and enter DROP, keeping the old address on imem_addr_o.
REQ-021 In DROP, a further redirect_i SHALL overwrite the latched target. On ack the data SHALL be discarded, pc SHALL take the latched target (or redirect_pc_i if redirect_i is also 1) and the state SHALL return to FETCH.
REQ-022 redirect_i=1 in BUFFERED SHALL discard the buffer, set pc<=redirect_pc_i and go to FETCH. In START, a redirect SHALL still load the PC.
REQ-023 redirect_pc_i[1:0] SHALL be forced to 2'b00 when loaded.
REQ-024 pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-025 imem_ack_i in START or BUFFERED SHALL be ignored.

Reset
REQ-026 While reset=0, the block SHALL immediately force: state=START, pc=RESET_PC, imem_req_o=0, ifid_valid_o=0, ifid_pc_o, ifid_pc4_o and ifid_instr_o all 0, skid buffer and latched target 0.
REQ-027 Reset asserted mid-request SHALL abandon the request with no later effect. The first request after reset release SHALL be to RESET_PC, one cycle after release.

Verification
REQ-028 Zero-wait memory (ack one cycle after req), no stall -> fetches at 0x0, 0x4, 0x8; ifid_pc_o advances by 4 each cycle; ifid_pc4_o=ifid_pc_o+4.
REQ-029 Ack at 0x4 with stall_i=1 for 3 cycles -> IF/ID holds 0x0 for 3 cycles, req=0; on release ifid_pc_o=0x4 with the correct word, then the fetch of 0x8.
REQ-030 Redirect to 0x103 while the req for 0x8 has no ack -> addr stays 0x8 until the 2-cycle-late ack; that word never becomes valid; the next req is to 0x100.
REQ-031 Two redirects (0x200, then 0x300) during one pending request -> the next fetch address is 0x300.
REQ-032 Redirect in the same cycle as stall_i=1 and ack=1 -> ifid_valid_o=0 next cycle, pc=target.
REQ-033 Redirect to 0xFFFF_FFFC -> the following fetch is 0x0. Reset pulse mid-request -> all outputs 0 immediately; first req after release is to RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// if_stage_if -- instruction memory bus between the fetch stage and memory.
//   imem_req_o   : fetch request, driven by the fetch stage
//   imem_addr_o  : fetch address, held stable from request until ack
//   imem_ack_i   : data-valid strobe from memory, one cycle per request
//   imem_rdata_i : instruction word, valid while imem_ack_i is 1
// Signal names match the original flat ports of if_stage.
interface if_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with a one-entry skid buffer and
// redirect handling for requests that are still outstanding.
//   clk           : clock, all state updates on the rising edge
//   reset         : asynchronous reset, active low
//   stall_i       : hold request from ID; IF/ID does not change while 1
//   redirect_i    : taken branch/jump from EX, has priority over stall_i
//   redirect_pc_i : redirect target (low two bits are ignored)
//   imem          : instruction memory bus (master side)
//   ifid_*_o      : IF/ID pipeline register (valid, pc, pc+4, instruction)
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    if_stage_if.master        imem,
    output logic              ifid_valid_o,
    output logic [31:0]       ifid_pc_o,
    output logic [31:0]       ifid_pc4_o,
    output logic [31:0]       ifid_instr_o
);

    typedef enum logic [1:0] {
        START    = 2'd0,
        FETCH    = 2'd1,
        BUFFERED = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] tgt_q, tgt_d;
    logic        valid_q, valid_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic [31:0] instr_q, instr_d;

    logic [31:0] redir_pc;
    logic [31:0] pc_inc;

    // Word-align the target; masking keeps every input bit in use.
    assign redir_pc = redirect_pc_i & ~32'd3;
    // 32-bit add wraps naturally modulo 2^32.
    assign pc_inc   = pc_q + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= START;
            pc_q    <= RESET_PC;
            skid_q  <= '0;
            tgt_q   <= '0;
            valid_q <= 1'b0;
            ipc_q   <= '0;
            ipc4_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        skid_d  = skid_q;
        tgt_d   = tgt_q;
        valid_d = valid_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        instr_d = instr_q;

        case (state_q)
            START: begin
                state_d = FETCH;
                if (redirect_i) begin
                    pc_d    = redir_pc;
                    valid_d = 1'b0;
                end
            end

            FETCH: begin
                if (redirect_i) begin
                    valid_d = 1'b0;
                    if (imem.imem_ack_i) begin
                        pc_d = redir_pc;
                    end else begin
                        // Address must stay put until the old request acks.
                        tgt_d   = redir_pc;
                        state_d = DROP;
                    end
                end else if (imem.imem_ack_i) begin
                    if (!stall_i) begin
                        valid_d = 1'b1;
                        ipc_d   = pc_q;
                        ipc4_d  = pc_inc;
                        instr_d = imem.imem_rdata_i;
                        pc_d    = pc_inc;
                    end else begin
                        // pc keeps the buffered word's address until it drains.
                        skid_d  = imem.imem_rdata_i;
                        state_d = BUFFERED;
                    end
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                end
            end

            BUFFERED: begin
                if (redirect_i) begin
                    valid_d = 1'b0;
                    pc_d    = redir_pc;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    valid_d = 1'b1;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_inc;
                    instr_d = skid_q;
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end

            DROP: begin
                if (redirect_i) begin
                    valid_d = 1'b0;
                end
                if (imem.imem_ack_i) begin
                    pc_d    = redirect_i ? redir_pc : tgt_q;
                    state_d = FETCH;
                end else if (redirect_i) begin
                    tgt_d = redir_pc;
                end
            end

            default: begin
                state_d = START;
            end
        endcase
    end

    assign imem.imem_req_o  = (state_q == FETCH) || (state_q == DROP);
    assign imem.imem_addr_o = pc_q;

    assign ifid_valid_o = valid_q;
    assign ifid_pc_o    = ipc_q;
    assign ifid_pc4_o   = ipc4_q;
    assign ifid_instr_o = instr_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- directed bench for if_stage; memory acks are driven by hand.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;

    int unsigned npass;
    int unsigned ntotal;

    if_stage_if imem_bus ();

    if_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem_bus.master),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_instr_o  (ifid_instr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic req, input logic [31:0] addr, input string tag);
        check({tag, ".req"},  {31'd0, imem_bus.imem_req_o}, {31'd0, req});
        check({tag, ".addr"}, imem_bus.imem_addr_o, addr);
    endtask

    task automatic ifid(input logic v, input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] instr, input string tag);
        check({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, v});
        check({tag, ".pc"},    ifid_pc_o, pc);
        check({tag, ".pc4"},   ifid_pc4_o, pc4);
        check({tag, ".instr"}, ifid_instr_o, instr);
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic stall,
                         input logic redir, input logic [31:0] rpc);
        imem_bus.imem_ack_i   = ack;
        imem_bus.imem_rdata_i = rdata;
        stall_i               = stall;
        redirect_i            = redir;
        redirect_pc_i         = rpc;
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        reset  = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0);

        // Reset state
        step;
        step;
        bus(1'b0, 32'h0, "rst");
        ifid(1'b0, 32'h0, 32'h0, 32'h0, "rst");

        // Release: START for one cycle, then request RESET_PC
        reset = 1'b1;
        #1;
        bus(1'b0, 32'h0, "start");
        step;
        bus(1'b1, 32'h0, "first_req");

        // Zero-wait fetches 0x0, 0x4
        drive(1'b1, w(32'h0), 1'b0, 1'b0, '0);
        step;
        ifid(1'b1, 32'h0, 32'h4, w(32'h0), "f0");
        bus(1'b1, 32'h4, "f0");

        // Ack at 0x4 with stall: buffered, IF/ID holds 0x0, no request
        drive(1'b1, w(32'h4), 1'b1, 1'b0, '0);
        step;
        ifid(1'b1, 32'h0, 32'h4, w(32'h0), "stall1");
        bus(1'b0, 32'h4, "stall1");
        // Stray ack while buffered must be ignored
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
        step;
        ifid(1'b1, 32'h0, 32'h4, w(32'h0), "stall2");
        bus(1'b0, 32'h4, "stall2");
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        step;
        ifid(1'b1, 32'h0, 32'h4, w(32'h0), "stall3");
        bus(1'b0, 32'h4, "stall3");
        // Release: buffered word enters IF/ID, next fetch is 0x8
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        step;
        ifid(1'b1, 32'h4, 32'h8, w(32'h4), "unstall");
        bus(1'b1, 32'h8, "unstall");

        // Redirect to 0x103 while 0x8 is pending; ack arrives 2 cycles later
        drive(1'b0, '0, 1'b0, 1'b1, 32'h0000_0103);
        step;
        check("drop1.valid", {31'd0, ifid_valid_o}, 32'd0);
        bus(1'b1, 32'h8, "drop1");
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        step;
        bus(1'b1, 32'h8, "drop2");
        drive(1'b1, w(32'h8), 1'b0, 1'b0, '0);
        step;
        check("drop_ack.valid", {31'd0, ifid_valid_o}, 32'd0);
        bus(1'b1, 32'h100, "drop_ack");
        drive(1'b1, w(32'h100), 1'b0, 1'b0, '0);
        step;
        ifid(1'b1, 32'h100, 32'h104, w(32'h100), "f100");

        // Two redirects during one pending request: last one wins
        drive(1'b0, '0, 1'b0, 1'b1, 32'h200);
        step;
        drive(1'b0, '0, 1'b0, 1'b1, 32'h300);
        step;
        bus(1'b1, 32'h104, "dbl_drop");
        drive(1'b1, w(32'h104), 1'b0, 1'b0, '0);
        step;
        bus(1'b1, 32'h300, "dbl_redir");
        check("dbl_redir.valid", {31'd0, ifid_valid_o}, 32'd0);

        // Fetch 0x300, 0x304, then hold without ack, then bubble
        drive(1'b1, w(32'h300), 1'b0, 1'b0, '0);
        step;
        drive(1'b1, w(32'h304), 1'b0, 1'b0, '0);
        step;
        ifid(1'b1, 32'h304, 32'h308, w(32'h304), "f304");
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        step;
        ifid(1'b1, 32'h304, 32'h308, w(32'h304), "hold_noack");
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        step;
        check("bubble.valid", {31'd0, ifid_valid_o}, 32'd0);
        bus(1'b1, 32'h308, "bubble");

        // Redirect + stall + ack together; target 0xFFFF_FFFC
        drive(1'b1, w(32'h308), 1'b1, 1'b1, 32'hFFFF_FFFC);
        step;
        check("redir_stall.valid", {31'd0, ifid_valid_o}, 32'd0);
        bus(1'b1, 32'hFFFF_FFFC, "redir_stall");

        // Wrap: fetch after 0xFFFF_FFFC is 0x0
        drive(1'b1, w(32'hFFFF_FFFC), 1'b0, 1'b0, '0);
        step;
        ifid(1'b1, 32'hFFFF_FFFC, 32'h0, w(32'hFFFF_FFFC), "wrap");
        bus(1'b1, 32'h0, "wrap");

        // Redirect while buffered discards the buffer
        drive(1'b1, w(32'h0), 1'b1, 1'b0, '0);
        step;
        bus(1'b0, 32'h0, "buf");
        drive(1'b0, '0, 1'b1, 1'b1, 32'h40);
        step;
        check("buf_redir.valid", {31'd0, ifid_valid_o}, 32'd0);
        bus(1'b1, 32'h40, "buf_redir");

        // In DROP, redirect coinciding with ack takes the live target
        drive(1'b0, '0, 1'b0, 1'b1, 32'h80);
        step;
        drive(1'b1, w(32'h40), 1'b0, 1'b1, 32'h92);
        step;
        bus(1'b1, 32'h90, "drop_live");
        drive(1'b1, w(32'h90), 1'b0, 1'b0, '0);
        step;
        ifid(1'b1, 32'h90, 32'h94, w(32'h90), "f90");

        // Reset mid-request: outputs clear without a clock edge
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        #1;
        bus(1'b0, 32'h0, "rst_mid");
        ifid(1'b0, 32'h0, 32'h0, 32'h0, "rst_mid");
        drive(1'b1, w(32'h94), 1'b0, 1'b0, '0);
        step;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        #1;
        bus(1'b0, 32'h0, "rel_start");
        step;
        bus(1'b1, 32'h0, "rel_req");
        drive(1'b1, w(32'h0), 1'b0, 1'b0, '0);
        step;
        ifid(1'b1, 32'h0, 32'h4, w(32'h0), "rel_f0");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
